// File: rtl/ahb_params_pkg.sv
// Shared AHB-Lite encodings plus the burst-length and next-address helpers
// used by the address-phase sequencer.
package ahb_params_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int KB_SHIFT   = 10;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE      = 3'd0,
      HSIZE_HALF_WORD = 3'd1,
      HSIZE_WORD      = 3'd2
   } hsize_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_ERR
   } gen_state_t;

   // Wide enough for any supported ADDR_WIDTH; callers truncate the result.
   typedef logic [63:0] wide_addr_t;

   function automatic logic is_wrap(input hburst_t burst);
      return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
   endfunction

   function automatic logic [4:0] burst_beats(input hburst_t burst, input logic [4:0] len,
                                              input int max_len);
      logic [4:0] beats;
      case (burst)
         HBURST_SINGLE: beats = 5'd1;
         HBURST_INCR: begin
            if (len == 5'd0)             beats = 5'd1;
            else if (int'(len) > max_len) beats = 5'(max_len);
            else                          beats = len;
         end
         HBURST_WRAP4, HBURST_INCR4: beats = 5'd4;
         HBURST_WRAP8, HBURST_INCR8: beats = 5'd8;
         default:                    beats = 5'd16;
      endcase
      return beats;
   endfunction

   function automatic wide_addr_t addr_next(input wide_addr_t addr, input hburst_t burst,
                                            input hsize_t size);
      wide_addr_t step;
      wide_addr_t mask;
      step = wide_addr_t'(1) << size;
      if (is_wrap(burst)) begin
         mask = (wide_addr_t'(burst_beats(burst, 5'd0, 0)) << size) - wide_addr_t'(1);
         return (addr & ~mask) | ((addr + step) & mask);
      end
      return addr + step;
   endfunction

endpackage

// File: rtl/ahb_master_burst_gen.sv
// AHB-Lite master address-phase sequencer: turns one burst command into
// beat-by-beat HADDR/HTRANS/control, honouring stalls, wraps, 1KB breaks and ERROR.
module ahb_master_burst_gen
   import ahb_params_pkg::*;
#(
   parameter int ADDR_WIDTH = ahb_params_pkg::ADDR_WIDTH,
   parameter int MAX_LEN    = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [2:0]            cmd_burst,
   input  logic [2:0]            cmd_size,
   input  logic [4:0]            cmd_len,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   input  logic                  HREADY,
   input  logic                  HRESP,
   output logic                  burst_done,
   output logic                  burst_err
);

   gen_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   htrans_t               htrans_q, htrans_d;
   logic                  hwrite_q, hwrite_d;
   hsize_t                hsize_q, hsize_d;
   hburst_t               hburst_q, hburst_d;
   logic [4:0]            beats_q, beats_d;
   logic                  live_q;

   // Command decode for the burst about to be loaded.
   hsize_t                cmd_size_c;
   hburst_t               cmd_burst_c;
   logic [4:0]            cmd_beats_c;
   logic [ADDR_WIDTH-1:0] start_addr, last_addr;
   logic                  fixed_incr, reject;

   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic                  nxt_crosses_kb;
   logic                  last_accept, take;

   assign cmd_size_c  = (cmd_size > 3'd2) ? HSIZE_WORD : hsize_t'(cmd_size);
   assign cmd_burst_c = hburst_t'(cmd_burst);
   assign cmd_beats_c = burst_beats(cmd_burst_c, cmd_len, MAX_LEN);
   assign start_addr  = (cmd_addr >> cmd_size_c) << cmd_size_c;
   assign last_addr   = start_addr + (ADDR_WIDTH'(cmd_beats_c - 5'd1) << cmd_size_c);
   assign fixed_incr  = (cmd_burst_c == HBURST_INCR4) || (cmd_burst_c == HBURST_INCR8) ||
                        (cmd_burst_c == HBURST_INCR16);
   assign reject      = fixed_incr && (((start_addr ^ last_addr) >> KB_SHIFT) != '0);

   assign nxt_addr       = ADDR_WIDTH'(addr_next(wide_addr_t'(haddr_q), hburst_q, hsize_q));
   assign nxt_crosses_kb = ((haddr_q ^ nxt_addr) >> KB_SHIFT) != '0;

   // A new command may be taken in the same cycle the last beat is accepted.
   assign last_accept = (state_q == ST_ACTIVE) && HREADY && (beats_q == 5'd1);
   assign cmd_ready   = live_q && !HRESET && ((state_q == ST_IDLE) || last_accept);
   assign take        = cmd_valid && cmd_ready;
   assign burst_done  = last_accept && !HRESET;
   assign burst_err   = (state_q == ST_ERR);

   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      haddr_d  = haddr_q;
      htrans_d = htrans_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hburst_d = hburst_q;
      beats_d  = beats_q;

      case (state_q)
         ST_IDLE: htrans_d = HTRANS_IDLE;
         ST_ACTIVE: begin
            if (HREADY) begin
               if (beats_q == 5'd1) begin
                  state_d  = ST_IDLE;
                  htrans_d = HTRANS_IDLE;
               end else begin
                  haddr_d  = nxt_addr;
                  beats_d  = beats_q - 5'd1;
                  htrans_d = (hburst_q == HBURST_INCR && nxt_crosses_kb) ? HTRANS_NONSEQ
                                                                         : HTRANS_SEQ;
               end
            end else if (HRESP) begin
               state_d  = ST_ERR;
               htrans_d = HTRANS_IDLE;
            end
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         if (reject) begin
            state_d  = ST_ERR;
            htrans_d = HTRANS_IDLE;
         end else begin
            state_d  = ST_ACTIVE;
            haddr_d  = start_addr;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size_c;
            hburst_d = cmd_burst_c;
            beats_d  = cmd_beats_c;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         haddr_q  <= '0;
         htrans_q <= HTRANS_IDLE;
         hwrite_q <= 1'b0;
         hsize_q  <= HSIZE_BYTE;
         hburst_q <= HBURST_SINGLE;
         beats_q  <= '0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hburst_q <= hburst_d;
         beats_q  <= beats_d;
         live_q   <= 1'b1;
      end
   end

   assign HADDR  = haddr_q;
   assign HTRANS = htrans_q;
   assign HWRITE = hwrite_q;
   assign HSIZE  = hsize_q;
   assign HBURST = hburst_q;

endmodule

// File: tb/tb_ahb_master_burst_gen.sv
// Self-checking bench for ahb_master_burst_gen: directed corner cases plus
// randomized bursts compared against an arithmetic model of the address sequence.
module tb_ahb_master_burst_gen;

   localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_burst, cmd_size;
   logic [4:0]  cmd_len;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;
   logic        HREADY, HRESP;
   logic        burst_done, burst_err;

   int vectors     = 0;
   int miscompares = 0;

   bit [31:0]  exp_addr[$];
   logic [1:0] exp_trans[$];
   bit         exp_reject;

   ahb_master_burst_gen #(.ADDR_WIDTH(32), .MAX_LEN(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HREADY(HREADY), .HRESP(HRESP), .burst_done(burst_done), .burst_err(burst_err)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Expected beat list from the burst rules: beat count, alignment, wrap box, 1KB breaks.
   function automatic void model(input logic [2:0] burst, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [4:0] len);
      int n;
      bit [31:0] step, start, total, base, a;
      exp_addr.delete();
      exp_trans.delete();
      step  = 32'd1 << size;
      start = addr & ~(step - 32'd1);
      case (burst)
         3'd0:       n = 1;
         3'd1:       n = (len == 0) ? 1 : (len > 16) ? 16 : int'(len);
         3'd2, 3'd3: n = 4;
         3'd4, 3'd5: n = 8;
         default:    n = 16;
      endcase
      total      = step * n;
      exp_reject = (burst == 3'd3 || burst == 3'd5 || burst == 3'd7) &&
                   ((start % 1024) + total > 1024);
      base = start - (start % total);
      for (int i = 0; i < n; i++) begin
         if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6)
            a = base + (((start % total) + step * i) % total);
         else
            a = start + step * i;
         exp_addr.push_back(a);
         if (i == 0 || (burst == 3'd1 && (a % 1024) == 0)) exp_trans.push_back(T_NONSEQ);
         else                                               exp_trans.push_back(T_SEQ);
      end
   endfunction

   task automatic drive_cmd(input logic [2:0] burst, input logic [2:0] size,
                            input logic [31:0] addr, input logic [4:0] len, input logic wr);
      cmd_valid = 1'b1;
      cmd_burst = burst;
      cmd_size  = size;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_write = wr;
   endtask

   // Called just after a negedge with cmd_valid high; returns once cmd_ready is seen.
   task automatic wait_ready();
      int n = 0;
      #1;
      while (!cmd_ready && n < 40) begin
         @(negedge HCLK);
         #1;
         n++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
   endtask

   task automatic run_burst(input logic [2:0] burst, input logic [2:0] size,
                            input logic [31:0] addr, input logic [4:0] len, input logic wr,
                            input int stall_beat, input int stall_cycles, input int stall_pct);
      int n;
      model(burst, size, addr, len);
      n = exp_addr.size();
      @(negedge HCLK);
      HREADY = 1'b1;
      HRESP  = 1'b0;
      drive_cmd(burst, size, addr, len, wr);
      wait_ready();
      @(negedge HCLK);
      cmd_valid = 1'b0;
      if (exp_reject) begin
         #1;
         check("reject_err", burst_err, 1);
         check("reject_trans", HTRANS, T_IDLE);
         @(negedge HCLK);
         #1;
         check("reject_ready", cmd_ready, 1);
         check("reject_err_clear", burst_err, 0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         int stalls = 0;
         forever begin
            if (i == stall_beat) HREADY = (stalls >= stall_cycles);
            else HREADY = (stalls >= 3) || ($urandom_range(99) >= stall_pct);
            #1;
            check($sformatf("beat%0d_addr", i), HADDR, exp_addr[i]);
            check($sformatf("beat%0d_trans", i), HTRANS, exp_trans[i]);
            check($sformatf("beat%0d_burst", i), HBURST, burst);
            check($sformatf("beat%0d_size", i), HSIZE, size);
            check($sformatf("beat%0d_write", i), HWRITE, wr);
            check($sformatf("beat%0d_done", i), burst_done, (HREADY && i == n - 1));
            @(negedge HCLK);
            if (HREADY) break;
            stalls++;
         end
      end
      HREADY = 1'b1;
      #1;
      check("end_trans_idle", HTRANS, T_IDLE);
      check("end_ready", cmd_ready, 1);
   endtask

   initial begin
      logic [2:0]  r_burst, r_size;
      logic [31:0] r_addr;

      HRESET = 1'b1;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      cmd_valid = 1'b0;
      cmd_burst = '0;
      cmd_size  = '0;
      cmd_addr  = '0;
      cmd_len   = '0;
      cmd_write = 1'b0;
      repeat (3) @(negedge HCLK);
      #1;
      check("rst_htrans", HTRANS, T_IDLE);
      check("rst_haddr", HADDR, 0);
      check("rst_hwrite", HWRITE, 0);
      check("rst_hsize", HSIZE, 0);
      check("rst_hburst", HBURST, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_done", burst_done, 0);
      check("rst_err", burst_err, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      #1;
      check("rst_ready_lag", cmd_ready, 0);
      @(negedge HCLK);
      #1;
      check("rst_ready_rise", cmd_ready, 1);

      // Directed cases.
      run_burst(3'd3, 3'd2, 32'h100, 5'd0, 1'b1, -1, 0, 0);   // INCR4 word
      run_burst(3'd2, 3'd2, 32'h38,  5'd0, 1'b0, -1, 0, 0);   // WRAP4 word
      run_burst(3'd4, 3'd1, 32'h0E,  5'd0, 1'b1, -1, 0, 0);   // WRAP8 half
      run_burst(3'd1, 3'd2, 32'h3F8, 5'd4, 1'b0, -1, 0, 0);   // INCR across 1KB
      run_burst(3'd3, 3'd2, 32'h100, 5'd0, 1'b1, 1, 3, 0);    // INCR4 stalled on beat 1
      run_burst(3'd3, 3'd2, 32'h3F8, 5'd0, 1'b1, -1, 0, 0);   // INCR4 crossing: rejected
      run_burst(3'd0, 3'd0, 32'h13,  5'd0, 1'b1, -1, 0, 0);   // SINGLE byte
      run_burst(3'd1, 3'd1, 32'h7,   5'd0, 1'b0, -1, 0, 0);   // INCR len 0 -> 1, aligned down
      run_burst(3'd1, 3'd0, 32'hFF8, 5'd31, 1'b0, -1, 0, 0);  // INCR len clamped to 16
      run_burst(3'd7, 3'd2, 32'hFFFF_FFC0, 5'd0, 1'b0, -1, 0, 0); // INCR16 at top of space

      // Back-to-back SINGLE then INCR4 with no IDLE gap.
      @(negedge HCLK);
      HREADY = 1'b1;
      drive_cmd(3'd0, 3'd2, 32'h10, 5'd0, 1'b1);
      wait_ready();
      @(negedge HCLK);
      drive_cmd(3'd3, 3'd2, 32'h20, 5'd0, 1'b1);
      #1;
      check("b2b_single_addr", HADDR, 32'h10);
      check("b2b_single_trans", HTRANS, T_NONSEQ);
      check("b2b_single_done", burst_done, 1);
      check("b2b_ready", cmd_ready, 1);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      #1;
      check("b2b_incr_addr", HADDR, 32'h20);
      check("b2b_incr_trans", HTRANS, T_NONSEQ);
      check("b2b_incr_burst", HBURST, 3'd3);
      for (int i = 1; i < 4; i++) begin
         @(negedge HCLK);
         #1;
         check("b2b_seq_addr", HADDR, 32'h20 + 32'(4 * i));
         check("b2b_seq_trans", HTRANS, T_SEQ);
         check("b2b_seq_done", burst_done, (i == 3));
      end
      @(negedge HCLK);
      #1;
      check("b2b_idle", HTRANS, T_IDLE);

      // ERROR abort on beat 2 of WRAP8.
      @(negedge HCLK);
      drive_cmd(3'd4, 3'd1, 32'h0E, 5'd0, 1'b0);
      wait_ready();
      @(negedge HCLK);
      cmd_valid = 1'b0;
      #1;
      check("err_b0_addr", HADDR, 32'h0E);
      @(negedge HCLK);
      #1;
      check("err_b1_addr", HADDR, 32'h00);
      @(negedge HCLK);
      HREADY = 1'b0;
      HRESP  = 1'b1;
      #1;
      check("err_b2_addr", HADDR, 32'h02);
      check("err_b2_trans", HTRANS, T_SEQ);
      check("err_b2_noerr", burst_err, 0);
      @(negedge HCLK);
      HREADY = 1'b1;
      #1;
      check("err_trans_idle", HTRANS, T_IDLE);
      check("err_pulse", burst_err, 1);
      check("err_ready_low", cmd_ready, 0);
      check("err_no_done", burst_done, 0);
      @(negedge HCLK);
      HRESP = 1'b0;
      #1;
      check("err_pulse_end", burst_err, 0);
      check("err_ready_back", cmd_ready, 1);

      // Reset in the middle of INCR16.
      @(negedge HCLK);
      drive_cmd(3'd7, 3'd2, 32'h200, 5'd0, 1'b1);
      wait_ready();
      @(negedge HCLK);
      cmd_valid = 1'b0;
      repeat (3) @(negedge HCLK);
      #1;
      check("mid_addr", HADDR, 32'h20C);
      @(negedge HCLK);
      HRESET = 1'b1;
      #1;
      check("mid_rst_no_done", burst_done, 0);
      @(negedge HCLK);
      #1;
      check("mid_rst_trans", HTRANS, T_IDLE);
      check("mid_rst_addr", HADDR, 0);
      check("mid_rst_done", burst_done, 0);
      check("mid_rst_ready", cmd_ready, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      #1;
      check("mid_rst_ready_lag", cmd_ready, 0);
      @(negedge HCLK);
      #1;
      check("mid_rst_ready_rise", cmd_ready, 1);
      check("mid_rst_idle", HTRANS, T_IDLE);

      // Randomized bursts, half of them straddling a 1KB boundary.
      for (int k = 0; k < 60; k++) begin
         r_burst = 3'($urandom_range(7));
         r_size  = 3'($urandom_range(2));
         r_addr  = $urandom;
         if ($urandom_range(1) == 1) r_addr = (r_addr & ~32'h3FF) | (32'h3C0 + 32'($urandom_range(63)));
         run_burst(r_burst, r_size, r_addr, 5'($urandom_range(31)), 1'($urandom_range(1)),
                   -1, 0, 30);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
